// File: rtl/toggle_trace_pkg.sv
// rtl/toggle_trace_pkg.sv - shared state encoding and default parameters for the toggle trace accumulator
package toggle_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_NET_W       = 32;
  localparam int DEF_WIN_LEN     = 8;
  localparam int DEF_NUM_SAMPLES = 16;
  localparam int DEF_ACC_W       = 16;

endpackage

// File: rtl/popcount_hd.sv
// rtl/popcount_hd.sv - combinational Hamming distance between two net snapshots
module popcount_hd #(
  parameter int NET_W = 32,
  parameter int HD_W  = $clog2(NET_W + 1)
) (
  input  logic [NET_W-1:0] a,
  input  logic [NET_W-1:0] b,
  output logic [HD_W-1:0]  hd
);

  logic [NET_W-1:0] diff;
  logic [HD_W-1:0]  cnt;

  // Count the bits that toggled between the two snapshots
  always_comb begin
    diff = a ^ b;
    cnt  = '0;
    for (int i = 0; i < NET_W; i++) begin
      cnt = cnt + HD_W'(diff[i]);
    end
    hd = cnt;
  end

endmodule

// File: rtl/toggle_trace_acc.sv
// rtl/toggle_trace_acc.sv - windowed switching-activity trace built from net snapshot Hamming distances
module toggle_trace_acc
  import toggle_trace_pkg::*;
#(
  parameter int NET_W       = DEF_NET_W,
  parameter int WIN_LEN     = DEF_WIN_LEN,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int IDX_W       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             snap_valid,
  input  logic [NET_W-1:0] snap,
  output logic             snap_ready,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [ACC_W-1:0] sample_data,
  output logic [IDX_W-1:0] sample_idx,
  output logic             sample_sat,
  output logic             busy,
  output logic             done
);

  localparam int HD_W  = $clog2(NET_W + 1);
  localparam int WC_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int SUM_W = ((ACC_W > HD_W) ? ACC_W : HD_W) + 1;

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [WC_W-1:0]  LAST_WIN = WC_W'(WIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  state_t           state;
  logic [NET_W-1:0] prev;
  logic [ACC_W-1:0] acc;
  logic [WC_W-1:0]  win_cnt;
  logic [IDX_W-1:0] idx;
  logic             sat;
  logic             done_r;

  logic [HD_W-1:0]  hd;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_add;
  logic             sat_add;

  popcount_hd #(
    .NET_W (NET_W),
    .HD_W  (HD_W)
  ) u_hd (
    .a  (snap),
    .b  (prev),
    .hd (hd)
  );

  // Saturating accumulate; sat is sticky for the rest of the window
  always_comb begin
    sum = SUM_W'(acc) + SUM_W'(hd);
    if (sum > SUM_W'(ACC_MAX)) begin
      acc_add = ACC_MAX;
      sat_add = 1'b1;
    end else begin
      acc_add = sum[ACC_W-1:0];
      sat_add = sat;
    end
  end

  // Capture-run FSM: prime on first snapshot, sum WIN_LEN transitions, hold sample until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= '0;
      acc     <= '0;
      win_cnt <= '0;
      idx     <= '0;
      sat     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= PRIME;
          end
        end
        PRIME: begin
          if (snap_valid) begin
            prev    <= snap;
            acc     <= '0;
            win_cnt <= '0;
            sat     <= 1'b0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (snap_valid) begin
            acc  <= acc_add;
            sat  <= sat_add;
            prev <= snap;
            if (win_cnt == LAST_WIN) begin
              state <= HOLD;
            end else begin
              win_cnt <= win_cnt + WC_W'(1);
            end
          end
        end
        HOLD: begin
          if (sample_ready) begin
            acc     <= '0;
            win_cnt <= '0;
            sat     <= 1'b0;
            if (idx == LAST_IDX) begin
              idx    <= '0;
              done_r <= 1'b1;
              state  <= IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ACCUM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign snap_ready   = (state == PRIME) || (state == ACCUM);
  assign sample_valid = (state == HOLD);
  assign busy         = (state != IDLE);
  assign sample_data  = acc;
  assign sample_idx   = idx;
  assign sample_sat   = sat;
  assign done         = done_r;

endmodule

// File: tb/tb_toggle_trace_acc.sv
// tb/tb_toggle_trace_acc.sv - scoreboard bench for toggle_trace_acc with 16-bit and 4-bit accumulators
module tb_toggle_trace_acc;

  localparam int NW = 8;
  localparam int WL = 4;
  localparam int NS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       snap_valid;
  logic [7:0] snap;
  logic       sample_ready;

  logic        snap_ready, sample_valid, sample_sat, busy, done;
  logic [15:0] sample_data;
  logic        sample_idx;

  logic        r4_snap_ready, r4_sample_valid, r4_sample_sat, r4_busy, r4_done;
  logic [3:0]  r4_sample_data;
  logic        r4_sample_idx;

  always #5 clk = ~clk;

  toggle_trace_acc #(.NET_W(NW), .WIN_LEN(WL), .NUM_SAMPLES(NS), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .snap_valid(snap_valid), .snap(snap),
    .snap_ready(snap_ready), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_idx(sample_idx), .sample_sat(sample_sat),
    .busy(busy), .done(done)
  );

  toggle_trace_acc #(.NET_W(NW), .WIN_LEN(WL), .NUM_SAMPLES(NS), .ACC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .snap_valid(snap_valid), .snap(snap),
    .snap_ready(r4_snap_ready), .sample_valid(r4_sample_valid), .sample_ready(sample_ready),
    .sample_data(r4_sample_data), .sample_idx(r4_sample_idx), .sample_sat(r4_sample_sat),
    .busy(r4_busy), .done(r4_done)
  );

  typedef struct {
    int d16;
    bit s16;
    int d4;
    bit s4;
    int idx;
    bit last;
  } exp_t;

  exp_t       q[$];
  logic [7:0] snaps[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each sample is the plain sum of bit flips between consecutive snapshots of its window
  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < NS; k++) begin
      int total = 0;
      for (int i = 1; i <= WL; i++) begin
        total += $countones(snaps[k*WL + i] ^ snaps[k*WL + i - 1]);
      end
      e.d16  = (total > 65535) ? 65535 : total;
      e.s16  = (total > 65535);
      e.d4   = (total > 15) ? 15 : total;
      e.s4   = (total > 15);
      e.idx  = k;
      e.last = (k == NS - 1);
      q.push_back(e);
    end
  endtask

  task automatic build_random(input bit heavy);
    snaps.delete();
    for (int i = 0; i < NS*WL + 1; i++) begin
      if (heavy) snaps.push_back((i % 2 == 0) ? 8'h00 : 8'(~$urandom_range(0, 3)));
      else       snaps.push_back(8'($urandom));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_snap_ready"}, snap_ready, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_sample_data"}, sample_data, 0);
    chk({tag, "_sample_idx"}, sample_idx, 0);
    chk({tag, "_sample_sat"}, sample_sat, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_r4_outputs"}, {r4_snap_ready, r4_sample_valid, r4_sample_data, r4_sample_idx,
                               r4_sample_sat, r4_busy, r4_done}, 0);
  endtask

  // Offer the snapshot list in order, advancing only on accepted handshakes
  task automatic drive_run(input int stop_after, input bit dense);
    int idx = 0;
    int budget = 0;
    int limit = (stop_after < 0) ? snaps.size() : stop_after;
    bit lat = 0;
    @(negedge clk);
    start = 1'b1;
    snap_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (idx < limit) begin
      if (budget > 0) @(negedge clk);
      budget++;
      if (lat) begin
        chk("window_latency", sample_valid, 1);
        lat = 0;
      end
      if (budget > 3000) begin
        chk("drive_timeout", idx, limit);
        break;
      end
      snap_valid = dense ? 1'b1 : ($urandom % 4 != 0);
      snap = snaps[idx];
      start = ($urandom % 8 == 0);
      if (snap_valid && snap_ready) begin
        if (idx > 0 && idx % WL == 0) lat = 1;
        idx++;
      end
    end
    @(negedge clk);
    if (lat) chk("window_latency", sample_valid, 1);
    snap_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() > 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("drain_queue_empty", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("idle_after_run", busy, 0);
  endtask

  // Downstream ready with bursts of backpressure, changed just after the rising edge
  initial begin
    sample_ready = 1'b0;
    forever begin
      logic lvl;
      int n;
      lvl = ($urandom % 3 != 0);
      n = $urandom_range(1, 4);
      repeat (n) begin
        @(posedge clk);
        #1 sample_ready = lvl;
      end
    end
  end

  // Monitor: pop and compare on every sample handshake, check the done pulse afterwards
  initial begin
    bit pend = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("done_pulse", done, 1);
          chk("busy_after_done", busy, 0);
          chk("r4_done_pulse", r4_done, 1);
          pend = 0;
        end else if (done) begin
          chk("unexpected_done", done, 0);
        end
        if (sample_valid) begin
          chk("hold_snap_ready", snap_ready, 0);
          chk("r4_sample_valid", r4_sample_valid, 1);
        end
        if (sample_valid && sample_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_sample", 1, 0);
          end else begin
            e = q.pop_front();
            chk("sample_data", sample_data, e.d16);
            chk("sample_sat", sample_sat, e.s16);
            chk("sample_idx", sample_idx, e.idx);
            chk("r4_sample_data", r4_sample_data, e.d4);
            chk("r4_sample_sat", r4_sample_sat, e.s4);
            chk("r4_sample_idx", r4_sample_idx, e.idx);
            if (e.last) pend = 1;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    snap_valid = 1'b0;
    snap = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic window, saturation on the narrow instance, then continuation with retained prev
    snaps.delete();
    snaps = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    push_expected();
    drive_run(-1, 1'b1);
    drain();

    // Abort after two transitions: reset mid-run, no sample or done may follow
    build_random(1'b0);
    drive_run(3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_sample", sample_valid, 0);
      chk("abort_no_done", done, 0);
    end

    // Fresh run after abort, then randomized runs
    for (int r = 0; r < 24; r++) begin
      build_random(r % 4 == 1);
      push_expected();
      drive_run(-1, r % 3 == 0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_trace_acc.md
TOGGLE_TRACE_ACC -- requirements
Module: toggle_trace_acc

Interface
REQ-001 Parameter NET_W, default 32: width of the gate-level net snapshot being observed.
REQ-002 Parameter WIN_LEN, default 8: snapshot transitions summed per trace sample (>=1).
REQ-003 Parameter NUM_SAMPLES, default 16: trace samples per capture run (>=1).
REQ-004 Parameter ACC_W, default 16: trace sample width; saturating.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: single-cycle request to begin a capture run; honoured only in IDLE.
REQ-008 Port snap_valid, input, 1: snap carries a new net snapshot this cycle.
REQ-009 Port snap, input, NET_W: net values from the instrumented netlist.
REQ-010 Port snap_ready, output, 1: block accepts a snapshot this cycle; high only in PRIME and ACCUM.
REQ-011 Port sample_valid, output, 1: trace sample available; high only in HOLD.
REQ-012 Port sample_ready, input, 1: downstream consumes the sample when sample_valid and sample_ready are both high.
REQ-013 Port sample_data, output, ACC_W: summed Hamming distance for one window.
REQ-014 Port sample_idx, output, clog2(NUM_SAMPLES): index of the current sample, starting at 0.
REQ-015 Port sample_sat, output, 1: the current sample saturated.
REQ-016 Port busy, output, 1: state is not IDLE.
REQ-017 Port done, output, 1: single-cycle pulse when the last sample is consumed.

Function
REQ-018 FSM states SHALL be IDLE, PRIME, ACCUM and HOLD.
REQ-019 IDLE->PRIME on start; start in any other state SHALL be ignored.
REQ-020 PRIME: on an accepted snapshot (snap_valid and snap_ready), store snap in prev, clear acc, win_cnt and sat, then go to ACCUM; no Hamming distance is added.
REQ-021 ACCUM: on an accepted snapshot, hd = popcount(snap XOR prev); acc <= sat_add(acc, hd); prev <= snap; win_cnt++.
REQ-022 Saturating add SHALL clamp at 2^ACC_W-1 and set sat; sat stays set until the window clears.
REQ-023 When the WIN_LEN-th transition is accepted, the next state SHALL be HOLD; sample_data reflects acc including that transition.
REQ-024 Cycles without snap_valid in PRIME or ACCUM SHALL change no state.
REQ-025 HOLD: sample_valid=1, snap_ready=0; sample_data, sample_idx and sample_sat SHALL be held stable until the handshake.
REQ-026 On handshake with sample_idx<NUM_SAMPLES-1: sample_idx++, clear acc, win_cnt and sat, keep prev, go to ACCUM; no re-prime.
REQ-027 On handshake with sample_idx==NUM_SAMPLES-1: pulse done for 1 cycle, clear sample_idx, go to IDLE.
REQ-028 Latency from accepting the last transition of a window to sample_valid SHALL be 1 cycle.
REQ-029 Full throughput: one snapshot per cycle in ACCUM; one HOLD cycle per window when sample_ready is high.

Reset
REQ-030 On rst_n low, the block SHALL go to IDLE immediately and clear prev, acc, win_cnt, sample_idx and sat.
REQ-031 Output values during reset: snap_ready=0, sample_valid=0, sample_data=0, sample_idx=0, sample_sat=0, busy=0, done=0.
REQ-032 Reset asserted mid-run SHALL discard the partial window; no sample and no done SHALL be emitted.

Structure
REQ-033 Package toggle_trace_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 Sub-module popcount_hd (NET_W in, clog2(NET_W+1) out) SHALL be purely combinational and SHALL compute popcount(a XOR b).

Verification (NET_W=8, WIN_LEN=4, NUM_SAMPLES=2, ACC_W=16 unless noted)
REQ-035 Reset: assert rst_n=0 mid-stream -> all outputs 0 and state IDLE the same cycle.
REQ-036 Basic: start, then snaps 00,FF,00,FF,00 -> sample_data=32, sample_idx=0, sample_sat=0, sample_valid 1 cycle after the fifth snap.
REQ-037 Backpressure: hold sample_ready=0 for 3 cycles -> sample_valid, sample_data=32 and snap_ready=0 held; snaps offered in this period are not accepted.
REQ-038 Continuation: after sample 0, snaps 01,03,07,0F -> sample_data=4, sample_idx=1 (prev=00 retained); on handshake, done pulses 1 cycle and busy drops.
REQ-039 Saturation with ACC_W=4: snaps 00,FF,00,FF,00 -> sample_data=15, sample_sat=1; next window clears sat.
REQ-040 Abort: reset after 2 transitions in ACCUM, then start -> PRIME is re-entered and the first sample covers only the new 4 transitions.
